clk_div_bank: RTL and testbench

Parametrised, multi-channel programmable clock-enable divider. Produces, per channel, a one-cycle `tick` strobe and a registered near-50% divided square wave from the single 100 MHz fabric clock, with a run-time divide ratio, per-channel enable, and a global phase-align restart. It replaces the fixed divide-by-4 stage that feeds the single-cycle RISC-V core. It also supplies additional rates (UART baud, display refresh, debounce) from one block.

---
 rtl/clk_div_bank.sv | 125 ++++++++++++
 tb/tb_clk_div_bank.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/clk_div_bank.sv
// Multi-channel programmable clock-enable divider: per-channel tick strobe and
// near-50% divided square wave, with glitch-free ratio updates and global restart.
module clk_div_bank #(
  parameter int NUM_CH      = 2,
  parameter int CNT_W       = 8,
  parameter int DEFAULT_DIV = 4,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              sync_restart,
  input  logic              cfg_valid,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  output logic              cfg_ready,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] div_out
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);

  logic [NUM_CH-1:0] pend_vec;
  logic              ch_ok;
  logic              req_ok;
  logic              accept;
  logic              cfg_err_reg;

  assign ch_ok     = (int'(cfg_ch) < NUM_CH);
  assign req_ok    = ch_ok && (cfg_div != '0);
  assign cfg_ready = ch_ok ? !pend_vec[cfg_ch] : 1'b1;
  assign accept    = cfg_valid && cfg_ready;
  assign cfg_err   = cfg_err_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_err_reg <= 1'b0;
    end else begin
      cfg_err_reg <= accept && !req_ok;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [CNT_W-1:0] cnt_reg, cnt_next;
      logic [CNT_W-1:0] div_reg, div_next;
      logic [CNT_W-1:0] pend_div_reg, pend_div_next;
      logic             pend_reg, pend_next;
      logic             en_q_reg;
      logic             tick_reg, tick_next;
      logic             div_out_reg, div_out_next;
      logic             hit;
      logic             wrap;

      assign hit  = accept && req_ok && (int'(cfg_ch) == gi);
      assign wrap = (cnt_reg == div_reg - ONE);

      always_comb begin
        cnt_next      = cnt_reg;
        div_next      = div_reg;
        pend_next     = pend_reg;
        pend_div_next = pend_div_reg;
        if (ch_en[gi]) begin
          // A pending ratio only takes effect on a period boundary.
          if (sync_restart || wrap) begin
            cnt_next = '0;
            if (pend_reg) begin
              div_next  = pend_div_reg;
              pend_next = 1'b0;
            end
          end else begin
            cnt_next = cnt_reg + ONE;
          end
          if (hit) begin
            pend_next     = 1'b1;
            pend_div_next = cfg_div;
          end
        end else begin
          cnt_next = '0;
          if (pend_reg) begin
            div_next  = pend_div_reg;
            pend_next = 1'b0;
          end
          if (hit) begin
            div_next = cfg_div;
          end
        end
      end

      // Outputs are decoded from next-state so they are registered yet aligned.
      always_comb begin
        tick_next    = ch_en[gi] && (cnt_next == div_next - ONE);
        div_out_next = ch_en[gi] && (cnt_next != '0) && (cnt_next <= (div_next >> 1));
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_reg      <= '0;
          div_reg      <= DIV_RST;
          pend_reg     <= 1'b0;
          pend_div_reg <= '0;
          en_q_reg     <= 1'b0;
          tick_reg     <= 1'b0;
          div_out_reg  <= 1'b0;
        end else begin
          cnt_reg      <= cnt_next;
          div_reg      <= div_next;
          pend_reg     <= pend_next;
          pend_div_reg <= pend_div_next;
          en_q_reg     <= ch_en[gi];
          tick_reg     <= tick_next;
          div_out_reg  <= div_out_next;
        end
      end

      assign pend_vec[gi] = pend_reg;
      assign tick[gi]     = tick_reg && en_q_reg;
      assign div_out[gi]  = div_out_reg && en_q_reg;
    end
  endgenerate

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed self-checking bench for clk_div_bank (three channels so that an
// out-of-range channel number can be driven).
module tb_clk_div_bank;

  localparam int NUM_CH = 3;
  localparam int CNT_W  = 8;
  localparam int CH_W   = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NUM_CH-1:0] ch_en = '0;
  logic              sync_restart = 1'b0;
  logic              cfg_valid = 1'b0;
  logic [CH_W-1:0]   cfg_ch = '0;
  logic [CNT_W-1:0]  cfg_div = '0;
  logic              cfg_ready;
  logic              cfg_err;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] div_out;

  int checks = 0;
  int errors = 0;

  clk_div_bank #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEFAULT_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .ch_en(ch_en), .sync_restart(sync_restart),
    .cfg_valid(cfg_valid), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
    .cfg_ready(cfg_ready), .cfg_err(cfg_err), .tick(tick), .div_out(div_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  // Inputs change on the falling edge; each step crosses exactly one rising edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ch_en = '0;
    sync_restart = 1'b0;
    cfg_valid = 1'b0;
    cfg_ch = '0;
    cfg_div = '0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // Per-cycle patterns, bit k = expected value in cycle k after the first edge.
  task automatic check_seq(input string tag, input int ch, input int n,
                           input logic [15:0] tp, input logic [15:0] dp);
    for (int k = 0; k < n; k++) begin
      step();
      check($sformatf("%s tick c%0d", tag, k), 32'(tick[ch]), 32'(tp[k]));
      check($sformatf("%s div c%0d", tag, k), 32'(div_out[ch]), 32'(dp[k]));
    end
  endtask

  initial begin
    // Reset defaults
    do_reset();
    check("rst tick", 32'(tick), 32'h0);
    check("rst div_out", 32'(div_out), 32'h0);
    check("rst cfg_err", 32'(cfg_err), 32'h0);
    check("rst cfg_ready", 32'(cfg_ready), 32'h1);

    // Default D=4 on two channels: 1100 pattern, tick on cnt=3
    ch_en = 3'b011;
    for (int k = 0; k < 8; k++) begin
      step();
      check($sformatf("d4 tick c%0d", k), 32'(tick), (k % 4 == 2) ? 32'h3 : 32'h0);
      check($sformatf("d4 div c%0d", k), 32'(div_out), (k % 4 < 2) ? 32'h3 : 32'h0);
    end

    // Ratio change 4 -> 6 requested at cnt=1; current period finishes at 4
    do_reset();
    ch_en = 3'b001;
    step();
    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd6;
    #1 check("chg ready before", 32'(cfg_ready), 32'h1);
    step();
    cfg_valid = 1'b0;
    check("chg ready pend", 32'(cfg_ready), 32'h0);
    check("chg div cnt2", 32'(div_out[0]), 32'h1);
    step();
    check("chg ready cnt3", 32'(cfg_ready), 32'h0);
    check("chg tick old wrap", 32'(tick[0]), 32'h1);
    step();
    check("chg ready after wrap", 32'(cfg_ready), 32'h1);
    check("chg tick after wrap", 32'(tick[0]), 32'h0);
    check_seq("d6", 0, 12, 16'h0410, 16'h01C7);

    // Configure disabled channel 1 to D=3, then enable
    do_reset();
    cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd3;
    step();
    cfg_valid = 1'b0;
    check("d3 cfg_err", 32'(cfg_err), 32'h0);
    check("d3 ready no pend", 32'(cfg_ready), 32'h1);
    ch_en = 3'b010;
    check_seq("d3", 1, 6, 16'h0012, 16'h0009);
    check("d3 ch0 idle", 32'(tick[0] | div_out[0]), 32'h0);

    // Rejected requests: zero ratio and out-of-range channel
    do_reset();
    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd0;
    step();
    cfg_valid = 1'b0;
    check("err div0 pulse", 32'(cfg_err), 32'h1);
    step();
    check("err div0 width", 32'(cfg_err), 32'h0);
    cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_div = 8'd5;
    #1 check("err badch ready", 32'(cfg_ready), 32'h1);
    step();
    cfg_valid = 1'b0;
    check("err badch pulse", 32'(cfg_err), 32'h1);
    step();
    check("err badch width", 32'(cfg_err), 32'h0);
    ch_en = 3'b001;
    check_seq("err keepD", 0, 8, 16'h0044, 16'h0033);

    // D=1: tick stuck high, div_out stuck low
    do_reset();
    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd1;
    step();
    cfg_valid = 1'b0;
    ch_en = 3'b001;
    check_seq("d1", 0, 4, 16'h000F, 16'h0000);

    // Out-of-phase D=4 and D=8 channels realigned by sync_restart
    do_reset();
    cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd8;
    step();
    cfg_valid = 1'b0;
    ch_en = 3'b001;
    step();
    step();
    ch_en = 3'b011;
    step();
    step();
    step();
    sync_restart = 1'b1;
    step();
    sync_restart = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (k > 0) step();
      check($sformatf("rs tick c%0d", k), 32'(tick),
            32'({1'b0, (k % 8 == 7), (k % 4 == 3)}));
      check($sformatf("rs div c%0d", k), 32'(div_out),
            32'({1'b0, (k % 8 >= 1 && k % 8 <= 4), (k % 4 == 1 || k % 4 == 2)}));
    end

    // Asynchronous reset mid-period discards a pending ratio
    do_reset();
    ch_en = 3'b001;
    step();
    step();
    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd6;
    step();
    cfg_valid = 1'b0;
    check("arst pend", 32'(cfg_ready), 32'h0);
    check("arst tick before", 32'(tick[0]), 32'h1);
    #3 rst_n = 1'b0;
    #1;
    check("arst tick now", 32'(tick), 32'h0);
    check("arst div now", 32'(div_out), 32'h0);
    check("arst ready now", 32'(cfg_ready), 32'h1);
    step();
    rst_n = 1'b1;
    check_seq("arst D4", 0, 8, 16'h0044, 16'h0033);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
